canvas_cell_memory: RTL and testbench



---
 rtl/canvas_cell_memory_if.sv | 23 ++
 rtl/canvas_cell_memory.sv | 200 ++++++++++++++++++++
 tb/tb_canvas_cell_memory.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/canvas_cell_memory_if.sv
// Draw/clear command and renderer read bundle for canvas_cell_memory.
// master = drawing controller plus renderer side; slave = the cell memory.
interface canvas_cell_memory_if;
  logic       drawPixel;
  logic       clearCanvas;
  logic [9:0] drawX;
  logic [8:0] drawY;
  logic [9:0] rdX;
  logic [8:0] rdY;
  logic       rdCell;
  logic       busy;
  logic       clearDone;

  modport master (
    output drawPixel, clearCanvas, drawX, drawY, rdX, rdY,
    input  rdCell, busy, clearDone
  );

  modport slave (
    input  drawPixel, clearCanvas, drawX, drawY, rdX, rdY,
    output rdCell, busy, clearDone
  );
endinterface

// File: rtl/canvas_cell_memory.sv
// Game-of-Life canvas: 1-bit-per-cell grid with clear sweep, draw port and registered read port.
// Optional macro CANVAS_TOGGLE_EN turns each draw into a read-modify-write that inverts the cell.
module canvas_cell_memory #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned CELL_SHIFT = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  canvas_cell_memory_if.slave bus
);

  localparam int unsigned GW    = H_RES >> CELL_SHIFT;
  localparam int unsigned GH    = V_RES >> CELL_SHIFT;
  localparam int unsigned CELLS = GW * GH;
  localparam int unsigned AW    = 13;
  localparam int unsigned XW    = 10;
  localparam int unsigned YW    = 9;

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

  // Row-major cell index; the multiply is by the constant grid width only.
  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y >> CELL_SHIFT) * AW'(GW) + AW'(x >> CELL_SHIFT);
  endfunction

  state_t        state, state_nx;
  logic [AW-1:0] sweep_addr, sweep_nx;
  logic          pend_valid, pend_valid_nx;
  logic [AW-1:0] pend_addr, pend_addr_nx;
  logic [AW-1:0] wr_addr, wr_addr_nx;
  logic          busy, busy_nx;
  logic          clear_done, clear_done_nx;
  logic          rd_cell;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_wdata;
  logic          write_last;
  logic          clear_after;

  logic          mem [0:CELLS-1];

  logic          draw_ok_c;
  logic [AW-1:0] draw_addr_c;
  logic          rd_ok_c;
  logic [AW-1:0] rd_addr_c;

`ifdef CANVAS_TOGGLE_EN
  logic phase, phase_nx;
  logic clear_req, clear_req_nx;
  logic rmw_q;
`endif

  assign draw_ok_c   = bus.drawPixel && (bus.drawX < XW'(H_RES)) && (bus.drawY < YW'(V_RES));
  assign draw_addr_c = cell_addr(bus.drawX, bus.drawY);
  assign rd_ok_c     = (bus.rdX < XW'(H_RES)) && (bus.rdY < YW'(V_RES)) && (state != CLEAR);
  assign rd_addr_c   = cell_addr(bus.rdX, bus.rdY);

  // Next-state, sweep, pending-draw and memory write control.
  always_comb begin
    state_nx      = state;
    sweep_nx      = sweep_addr;
    pend_valid_nx = pend_valid;
    pend_addr_nx  = pend_addr;
    wr_addr_nx    = wr_addr;
    clear_done_nx = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = wr_addr;
    mem_wdata     = 1'b0;
    write_last    = 1'b0;
    clear_after   = bus.clearCanvas;
`ifdef CANVAS_TOGGLE_EN
    phase_nx      = phase;
    clear_req_nx  = clear_req;
`endif

    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_addr;
        if (draw_ok_c) begin
          pend_valid_nx = 1'b1;
          pend_addr_nx  = draw_addr_c;
        end
        if (bus.clearCanvas) begin
          sweep_nx = '0;
        end else if (sweep_addr == AW'(CELLS - 1)) begin
          sweep_nx      = '0;
          clear_done_nx = 1'b1;
          if (pend_valid_nx) begin
            state_nx      = WRITE;
            wr_addr_nx    = pend_addr_nx;
            pend_valid_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          sweep_nx = sweep_addr + AW'(1);
        end
      end

      IDLE: begin
        if (bus.clearCanvas) begin
          state_nx = CLEAR;
          sweep_nx = '0;
        end else if (draw_ok_c) begin
          state_nx   = WRITE;
          wr_addr_nx = draw_addr_c;
        end
      end

      WRITE: begin
        if (draw_ok_c) begin
          pend_valid_nx = 1'b1;
          pend_addr_nx  = draw_addr_c;
        end
`ifdef CANVAS_TOGGLE_EN
        clear_after = bus.clearCanvas || clear_req;
        if (!phase) begin
          phase_nx = 1'b1;
          if (bus.clearCanvas) clear_req_nx = 1'b1;
        end else begin
          mem_we       = 1'b1;
          mem_wdata    = ~rmw_q;
          phase_nx     = 1'b0;
          clear_req_nx = 1'b0;
          write_last   = 1'b1;
        end
`else
        mem_we     = 1'b1;
        mem_wdata  = 1'b1;
        write_last = 1'b1;
`endif
        if (write_last) begin
          if (clear_after) begin
            state_nx = CLEAR;
            sweep_nx = '0;
          end else if (pend_valid_nx) begin
            state_nx      = WRITE;
            wr_addr_nx    = pend_addr_nx;
            pend_valid_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: begin
        state_nx = CLEAR;
        sweep_nx = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      wr_addr    <= '0;
      busy       <= 1'b1;
      clear_done <= 1'b0;
      rd_cell    <= 1'b0;
`ifdef CANVAS_TOGGLE_EN
      phase      <= 1'b0;
      clear_req  <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      sweep_addr <= sweep_nx;
      pend_valid <= pend_valid_nx;
      pend_addr  <= pend_addr_nx;
      wr_addr    <= wr_addr_nx;
      busy       <= busy_nx;
      clear_done <= clear_done_nx;
      rd_cell    <= rd_ok_c ? mem[rd_addr_c] : 1'b0;
`ifdef CANVAS_TOGGLE_EN
      phase      <= phase_nx;
      clear_req  <= clear_req_nx;
`endif
    end
  end

  // Simple dual-port storage: one write port, reads return pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
`ifdef CANVAS_TOGGLE_EN
    rmw_q <= mem[wr_addr];
`endif
  end

  assign bus.rdCell    = rd_cell;
  assign bus.busy      = busy;
  assign bus.clearDone = clear_done;

endmodule

// File: tb/tb_canvas_cell_memory.sv
// Directed bench for canvas_cell_memory: clear sweep, draws, range gating, clear restart.
// Build with CANVAS_TOGGLE_EN defined to exercise the toggle expectations.
module tb_canvas_cell_memory;

`ifdef CANVAS_TOGGLE_EN
  localparam int   EXP_BUSY   = 2;
  localparam logic EXP_REDRAW = 1'b0;
`else
  localparam int   EXP_BUSY   = 1;
  localparam logic EXP_REDRAW = 1'b1;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  canvas_cell_memory_if bus();

  canvas_cell_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input int x, input int y, output logic v);
    bus.rdX = 10'(x);
    bus.rdY = 9'(y);
    tick();
    v = bus.rdCell;
  endtask

  task automatic draw(input int x, input int y, output int busy_cycles);
    bus.drawX     = 10'(x);
    bus.drawY     = 9'(y);
    bus.drawPixel = 1'b1;
    tick();
    bus.drawPixel = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 8) begin
      busy_cycles++;
      tick();
    end
  endtask

  task automatic run_sweep(input int budget, output int done_at, output int low_cnt);
    done_at = -1;
    low_cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.clearDone) begin
        done_at = i;
        break;
      end
      if (!bus.busy) low_cnt++;
    end
  endtask

  initial begin
    logic v;
    int   bc;
    int   done_at;
    int   low_cnt;
    int   pulses;
    int   busy_at_done;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.drawPixel   = 1'b0;
    bus.clearCanvas = 1'b0;
    bus.drawX       = '0;
    bus.drawY       = '0;
    bus.rdX         = '0;
    bus.rdY         = '0;

    repeat (3) tick();
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_clear_done", 32'(bus.clearDone), 0);
    check("rst_rd_cell", 32'(bus.rdCell), 0);

    // Power-on sweep
    rst_n = 1'b1;
    run_sweep(6000, done_at, low_cnt);
    check("init_done_cycle", 32'(done_at), 4800);
    check("init_busy_low", 32'(low_cnt), 0);
    check("init_idle_busy", 32'(bus.busy), 0);
    tick();
    check("init_done_single", 32'(bus.clearDone), 0);
    read_at(0, 0, v);     check("init_rd_0_0", 32'(v), 0);
    read_at(639, 479, v); check("init_rd_639_479", 32'(v), 0);
    read_at(320, 240, v); check("init_rd_320_240", 32'(v), 0);

    // Single draw covers one 8x8 cell
    draw(17, 9, bc);
    check("draw_busy", 32'(bc), 32'(EXP_BUSY));
    read_at(16, 8, v);  check("cell_tl", 32'(v), 1);
    read_at(23, 15, v); check("cell_br", 32'(v), 1);
    read_at(17, 9, v);  check("cell_hit", 32'(v), 1);
    read_at(24, 9, v);  check("cell_right", 32'(v), 0);
    read_at(15, 8, v);  check("cell_left", 32'(v), 0);
    read_at(16, 7, v);  check("cell_above", 32'(v), 0);

    // Out-of-range draws are dropped
    draw(640, 10, bc);  check("oor_x_busy", 32'(bc), 0);
    draw(10, 480, bc);  check("oor_y_busy", 32'(bc), 0);
    read_at(639, 10, v); check("oor_rd_639_10", 32'(v), 0);
    read_at(0, 16, v);   check("oor_alias_0_16", 32'(v), 0);

    // Edge cells and read-side range gating
    draw(639, 479, bc); check("last_busy", 32'(bc), 32'(EXP_BUSY));
    read_at(639, 479, v); check("last_cell", 32'(v), 1);
    draw(0, 8, bc);
    read_at(0, 8, v);     check("row1_cell", 32'(v), 1);
    read_at(640, 0, v);   check("rd_x_gate", 32'(v), 0);
    read_at(0, 480, v);   check("rd_y_gate", 32'(v), 0);

    // Back-to-back draws: second one waits as pending
    bus.drawX = 10'd200; bus.drawY = 9'd200; bus.drawPixel = 1'b1;
    tick();
    bc = bus.busy ? 1 : 0;
    bus.drawX = 10'd300; bus.drawY = 9'd100;
    tick();
    bus.drawPixel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) bc++;
      tick();
    end
    check("b2b_busy", 32'(bc), 32'(2 * EXP_BUSY));
    read_at(200, 200, v); check("b2b_first", 32'(v), 1);
    read_at(300, 100, v); check("b2b_second", 32'(v), 1);

    // Redraw of a live cell
    draw(40, 40, bc);
    check("redraw1_busy", 32'(bc), 32'(EXP_BUSY));
    read_at(40, 40, v); check("redraw1_cell", 32'(v), 1);
    repeat (10) tick();
    draw(40, 40, bc);
    check("redraw2_busy", 32'(bc), 32'(EXP_BUSY));
    read_at(40, 40, v); check("redraw2_cell", 32'(v), 32'(EXP_REDRAW));

    // Clear wins over a simultaneous draw; display blanks during sweep
    bus.drawX = 10'd100; bus.drawY = 9'd100; bus.drawPixel = 1'b1; bus.clearCanvas = 1'b1;
    bus.rdX = 10'd17; bus.rdY = 9'd9;
    tick();
    bus.drawPixel = 1'b0; bus.clearCanvas = 1'b0;
    check("pre_clear_rd", 32'(bus.rdCell), 1);
    tick();
    check("clear_blank", 32'(bus.rdCell), 0);
    check("clear_busy", 32'(bus.busy), 1);
    run_sweep(6000, done_at, low_cnt);
    check("clr_done_cycle", 32'(done_at + 1), 4800);
    check("clr_busy_low", 32'(low_cnt), 0);
    tick();
    check("clr_idle", 32'(bus.busy), 0);
    read_at(100, 100, v); check("clr_drop_draw", 32'(v), 0);
    read_at(17, 9, v);    check("clr_wiped", 32'(v), 0);

    // Sweep restart keeps a pending draw; one done pulse after restart
    bus.clearCanvas = 1'b1;
    tick();
    bus.clearCanvas = 1'b0;
    bus.drawX = 10'd8; bus.drawY = 9'd8;
    pulses = 0; done_at = -1; busy_at_done = 0;
    for (int k = 1; k <= 6810; k++) begin
      bus.drawPixel   = (k == 10);
      bus.clearCanvas = (k == 2001);
      tick();
      if (bus.clearDone) begin
        pulses++;
        if (done_at < 0) begin
          done_at = k;
          busy_at_done = bus.busy ? 1 : 0;
        end
      end
    end
    bus.drawPixel = 1'b0; bus.clearCanvas = 1'b0;
    check("rst_sweep_pulses", 32'(pulses), 1);
    check("rst_sweep_done", 32'(done_at), 6801);
    check("rst_sweep_pend_busy", 32'(busy_at_done), 1);
    check("rst_sweep_idle", 32'(bus.busy), 0);
    read_at(8, 8, v); check("pend_cell", 32'(v), 1);
    read_at(0, 0, v); check("pend_neighbour", 32'(v), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
